// File: rtl/ram_burst.sv
`default_nettype none
// ============================================================================
// Module   : ram_burst
// Purpose  : Byte-banked on-board RAM with any-alignment multi-byte beats,
//            single-beat writes and incrementing read bursts. A valid/ready
//            request port feeds a one-stage RAM pipeline and a 2-entry
//            response FIFO with resp_ready backpressure.
// Ports    : clk_in, rst_in (sync, active high)
//            req_valid/req_ready handshake; req_we, req_addr, req_size,
//            req_len, req_wdata describe the request
//            resp_valid/resp_ready handshake; resp_rdata, resp_last, resp_err
// Options  : define RAM_MISALIGN_TRAP_EN to return an error beat (and skip
//            the RAM access) for requests not aligned to the clamped size.
// Revision : 1.0 - initial release
// ============================================================================
module ram_burst #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_BYTES = 4,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [1:0]              req_size,
    input  logic [LEN_WIDTH-1:0]    req_len,
    input  logic [8*DATA_BYTES-1:0] req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [8*DATA_BYTES-1:0] resp_rdata,
    output logic                    resp_last,
    output logic                    resp_err
);

    localparam int c_OFF_W    = $clog2(DATA_BYTES);
    localparam int c_NB_W     = c_OFF_W + 1;
    localparam int c_ROW_W    = ADDR_WIDTH - c_OFF_W;
    localparam int c_SIZE_MAX = c_OFF_W;
    localparam int c_DW       = 8 * DATA_BYTES;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    function automatic logic [1:0] clamp_size(input logic [1:0] s);
        if (int'(s) > c_SIZE_MAX) return 2'(c_SIZE_MAX);
        return s;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] size_step(input logic [1:0] s);
        return ADDR_WIDTH'(1) << s;
    endfunction

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [0:0]            r_state;
    logic [0:0]            w_state_next;

    logic [ADDR_WIDTH-1:0] r_burst_addr;
    logic [1:0]            r_burst_size;
    logic [LEN_WIDTH-1:0]  r_burst_left;   // beats still to issue

    logic                  r_inf_valid;
    logic                  r_inf_we;
    logic                  r_inf_err;
    logic                  r_inf_last;
    logic [c_OFF_W-1:0]    r_inf_off;
    logic [1:0]            r_inf_size;

    logic [c_DW-1:0]       r_fifo_data [2];
    logic [1:0]            r_fifo_last;
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;

    logic                  w_push;
    logic                  w_pop;
    logic [2:0]            w_occ;
    logic                  w_can_issue;
    logic                  w_accept;
    logic [1:0]            w_req_size_c;
    logic                  w_misalign;

    logic                  w_iss_valid;
    logic                  w_iss_we;
    logic                  w_iss_err;
    logic                  w_iss_last;
    logic [ADDR_WIDTH-1:0] w_iss_addr;
    logic [1:0]            w_iss_size;
    logic                  w_burst_load;
    logic                  w_burst_adv;

    logic [c_OFF_W-1:0]    w_iss_off;
    logic [c_ROW_W-1:0]    w_iss_row;
    logic [c_NB_W-1:0]     w_iss_nbytes;
    logic                  w_ram_wr;
    logic                  w_ram_rd;

    logic [7:0]            w_bank_q [DATA_BYTES];
    logic [c_NB_W-1:0]     w_inf_nbytes;
    logic [c_DW-1:0]       w_fmt;

    // ------------------------------------------------------------------
    // Flow control: a beat may be issued when the FIFO will have room for
    // it by the time it lands, counting the entry leaving this cycle.
    // ------------------------------------------------------------------
    assign w_pop       = resp_valid & resp_ready;
    assign w_push      = r_inf_valid;
    assign w_occ       = {1'b0, r_count} + {2'b00, r_inf_valid} - {2'b00, w_pop};
    assign w_can_issue = (w_occ < 3'd2);

    assign req_ready    = !rst_in && (r_state == S_IDLE) && w_can_issue;
    assign w_accept     = req_valid & req_ready;
    assign w_req_size_c = clamp_size(req_size);

`ifdef RAM_MISALIGN_TRAP_EN
    assign w_misalign = |(req_addr & (size_step(w_req_size_c) - ADDR_WIDTH'(1)));
`else
    assign w_misalign = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register + next-state / issue decode
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_inf_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_inf_valid <= w_iss_valid;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_iss_valid  = 1'b0;
        w_iss_we     = 1'b0;
        w_iss_err    = 1'b0;
        w_iss_last   = 1'b0;
        w_iss_addr   = r_burst_addr;
        w_iss_size   = r_burst_size;
        w_burst_load = 1'b0;
        w_burst_adv  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_iss_valid = 1'b1;
                    w_iss_we    = req_we;
                    w_iss_err   = w_misalign;
                    w_iss_addr  = req_addr;
                    w_iss_size  = w_req_size_c;
                    // A trapped read returns only its single error beat.
                    if (req_we || w_misalign || (req_len == '0)) begin
                        w_iss_last = 1'b1;
                    end else begin
                        w_burst_load = 1'b1;
                        w_state_next = S_BURST;
                    end
                end
            end
            S_BURST: begin
                if (w_can_issue && !rst_in) begin
                    w_iss_valid = 1'b1;
                    w_burst_adv = 1'b1;
                    w_iss_last  = (r_burst_left == LEN_WIDTH'(1));
                    if (w_iss_last) w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Burst address/count and the in-flight beat descriptor
    always_ff @(posedge clk_in) begin
        if (w_burst_load) begin
            r_burst_addr <= req_addr + size_step(w_req_size_c);
            r_burst_size <= w_req_size_c;
            r_burst_left <= req_len;
        end else if (w_burst_adv) begin
            r_burst_addr <= r_burst_addr + size_step(r_burst_size);
            r_burst_left <= r_burst_left - LEN_WIDTH'(1);
        end
        if (w_iss_valid) begin
            r_inf_we   <= w_iss_we;
            r_inf_err  <= w_iss_err;
            r_inf_last <= w_iss_last;
            r_inf_off  <= w_iss_off;
            r_inf_size <= w_iss_size;
        end
    end

    // ------------------------------------------------------------------
    // Byte banks. A beat starting at bank offset 'off' covers banks
    // off..DATA_BYTES-1 on 'row' and banks below 'off' on 'row+1', so
    // every beat is a single access across all banks.
    // ------------------------------------------------------------------
    assign w_iss_off    = w_iss_addr[c_OFF_W-1:0];
    assign w_iss_row    = w_iss_addr[ADDR_WIDTH-1:c_OFF_W];
    assign w_iss_nbytes = c_NB_W'(1) << w_iss_size;
    assign w_ram_wr     = w_iss_valid &  w_iss_we & !w_iss_err;
    assign w_ram_rd     = w_iss_valid & !w_iss_we & !w_iss_err;

    for (genvar b = 0; b < DATA_BYTES; b++) begin : g_bank
        logic [c_OFF_W-1:0] w_rel;   // byte lane this bank serves in the beat
        logic [c_ROW_W-1:0] w_row;
        logic               w_we;
        logic [7:0]         r_mem [2**c_ROW_W];
        logic [7:0]         r_q;

        assign w_rel = c_OFF_W'(b) - w_iss_off;
        assign w_row = (c_OFF_W'(b) < w_iss_off) ? (w_iss_row + c_ROW_W'(1)) : w_iss_row;
        assign w_we  = w_ram_wr && ({1'b0, w_rel} < w_iss_nbytes);

        always_ff @(posedge clk_in) begin
            if (w_we)     r_mem[w_row] <= req_wdata[8*w_rel +: 8];
            if (w_ram_rd) r_q          <= r_mem[w_row];
        end

        assign w_bank_q[b] = r_q;
    end

    // Rotate bank outputs back into beat byte order and zero-extend
    assign w_inf_nbytes = c_NB_W'(1) << r_inf_size;

    always_comb begin
        w_fmt = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (c_NB_W'(i) < w_inf_nbytes) begin
                w_fmt[8*i +: 8] = w_bank_q[r_inf_off + c_OFF_W'(i)];
            end
        end
        if (r_inf_we || r_inf_err) w_fmt = '0;
    end

    // ------------------------------------------------------------------
    // 2-entry response FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= w_fmt;
            r_fifo_last[r_wr_ptr] <= r_inf_last;
        end
    end

    assign resp_valid = (r_count != 2'd0);
    assign resp_rdata = resp_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign resp_last  = resp_valid & r_fifo_last[r_rd_ptr];

`ifdef RAM_MISALIGN_TRAP_EN
    logic [1:0] r_fifo_err;

    always_ff @(posedge clk_in) begin
        if (w_push) r_fifo_err[r_wr_ptr] <= r_inf_err;
    end

    assign resp_err = resp_valid & r_fifo_err[r_rd_ptr];
`else
    assign resp_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_burst.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_burst
// Purpose  : Self-checking bench for ram_burst. Requests push expected beats
//            (from a byte-array memory model) into a scoreboard queue; a
//            monitor pops and compares on every response handshake and
//            checks that stalled responses hold steady.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_burst;

    localparam int AW  = 17;
    localparam int DB  = 4;
    localparam int LW  = 4;
    localparam int DW  = 8 * DB;
    localparam int CAP = 1 << AW;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [1:0]    req_size;
    logic [LW-1:0] req_len;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          resp_last;
    logic          resp_err;

    ram_burst #(.ADDR_WIDTH(AW), .DATA_BYTES(DB), .LEN_WIDTH(LW)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_len   (req_len),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_last (resp_last),
        .resp_err  (resp_err)
    );

    always #5 clk_in = ~clk_in;

    // ------------------------------------------------------------------
    // Reference model: flat byte memory plus a known-byte map
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [DW-1:0] data;
        logic [DW-1:0] mask;
        logic          last;
        logic          err;
    } exp_t;

    logic [7:0] m_data  [CAP];
    bit         m_known [CAP];
    exp_t       sb_q [$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic model_req(input bit we, input int addr, input int size,
                             input int len, input logic [DW-1:0] wd);
        int   nb;
        int   base;
        int   a;
        bit   mis;
        exp_t e;
        nb  = 1 << ((size > 2) ? 2 : size);
        mis = 1'b0;
`ifdef RAM_MISALIGN_TRAP_EN
        mis = (addr % nb) != 0;
`endif
        if (mis) begin
            e = '{data: '0, mask: '1, last: 1'b1, err: 1'b1};
            sb_q.push_back(e);
        end else if (we) begin
            for (int i = 0; i < nb; i++) begin
                a = (addr + i) % CAP;
                m_data[a]  = wd[8*i +: 8];
                m_known[a] = 1'b1;
            end
            e = '{data: '0, mask: '1, last: 1'b1, err: 1'b0};
            sb_q.push_back(e);
        end else begin
            for (int k = 0; k <= len; k++) begin
                base = (addr + k * nb) % CAP;
                e.data = '0;
                e.mask = '1;
                for (int i = 0; i < nb; i++) begin
                    a = (base + i) % CAP;
                    if (m_known[a]) e.data[8*i +: 8] = m_data[a];
                    else            e.mask[8*i +: 8] = 8'h00;
                end
                e.last = (k == len);
                e.err  = 1'b0;
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Response backpressure driver
    // ------------------------------------------------------------------
    int rr_low  = 0;
    bit rr_rand = 1'b0;

    initial begin
        resp_ready = 1'b1;
        forever begin
            @(posedge clk_in);
            #1;
            if (rr_low > 0) begin
                resp_ready = 1'b0;
                rr_low--;
            end else begin
                resp_ready = rr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic          prev_err;

    always @(negedge clk_in) begin : mon
        exp_t e;
        if (rst_in) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_checks++;
                if (!resp_valid || resp_rdata !== prev_data || resp_last !== prev_last
                    || resp_err !== prev_err) begin
                    n_fail++;
                    $display("FAIL hold_stable: got v=%0b d=0x%0h l=%0b e=%0b, expected v=1 d=0x%0h l=%0b e=%0b",
                             resp_valid, resp_rdata, resp_last, resp_err, prev_data, prev_last, prev_err);
                end
            end
            prev_stall = 1'b0;
            if (resp_valid) begin
                if (resp_ready) begin
                    n_checks++;
                    if (sb_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_beat: got d=0x%0h l=%0b e=%0b, expected no beat",
                                 resp_rdata, resp_last, resp_err);
                    end else begin
                        e = sb_q.pop_front();
                        if (((resp_rdata ^ e.data) & e.mask) != '0 || resp_last !== e.last
                            || resp_err !== e.err) begin
                            n_fail++;
                            $display("FAIL beat: got d=0x%0h l=%0b e=%0b, expected d=0x%0h (mask 0x%0h) l=%0b e=%0b",
                                     resp_rdata, resp_last, resp_err, e.data, e.mask, e.last, e.err);
                        end
                    end
                end else begin
                    prev_stall = 1'b1;
                    prev_data  = resp_rdata;
                    prev_last  = resp_last;
                    prev_err   = resp_err;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called just after a rising edge)
    // ------------------------------------------------------------------
    task automatic issue(input bit we, input int addr, input int size, input int len,
                         input logic [DW-1:0] wd);
        bit acc;
        bit got;
        got       = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = AW'(addr);
        req_size  = 2'(size);
        req_len   = LW'(len);
        req_wdata = wd;
        for (int t = 0; t < 300 && !got; t++) begin
            @(negedge clk_in);
            acc = req_ready;
            @(posedge clk_in);
            if (acc) begin
                model_req(we, addr, size, len, wd);
                got = 1'b1;
            end
            #1;
        end
        req_valid = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_accept_timeout: got no acceptance, expected acceptance within 300 cycles");
        end
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge clk_in);
            if (sb_q.size() == 0 && !resp_valid) done = 1'b1;
        end
        @(posedge clk_in);
        #1;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", sb_q.size());
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        for (int i = 0; i < CAP; i++) m_known[i] = 1'b0;
        rst_in    = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_size  = '0;
        req_len   = '0;
        req_wdata = '0;
        step(3);
        @(negedge clk_in);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_last", 32'(resp_last), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk_in);
        #1;

        // 1: write then read back with latency check
        issue(1'b1, 32'h00100, 2, 0, 32'hDEADBEEF);
        wait_drain();
        issue(1'b0, 32'h00100, 2, 0, 32'h0);
        @(negedge clk_in);
        check("latency_cycle1_valid", 32'(resp_valid), 32'd0);
        @(negedge clk_in);
        check("latency_cycle2_valid", 32'(resp_valid), 32'd1);
        @(posedge clk_in);
        #1;
        wait_drain();

        // 2: byte write, byte read, word read
        issue(1'b1, 32'h00103, 0, 0, 32'h000000AA);
        issue(1'b0, 32'h00103, 0, 0, 32'h0);
        issue(1'b0, 32'h00100, 2, 0, 32'h0);

        // 3: unaligned word read straddling two rows
        issue(1'b1, 32'h00104, 2, 0, 32'h11223344);
        issue(1'b0, 32'h00102, 2, 0, 32'h0);
        issue(1'b0, 32'h00101, 3, 0, 32'h0);   // size 3 clamps to a word
        wait_drain();

        // 4: burst wrapping past the top of memory
        issue(1'b1, 32'h1FFF8, 2, 0, 32'hA0A1A2A3);
        issue(1'b1, 32'h1FFFC, 2, 0, 32'hB0B1B2B3);
        issue(1'b1, 32'h00000, 2, 0, 32'hC0C1C2C3);
        issue(1'b1, 32'h00004, 2, 0, 32'hD0D1D2D3);
        issue(1'b0, 32'h1FFF8, 2, 3, 32'h0);
        issue(1'b0, 32'h1FFFE, 1, 1, 32'h0);
        wait_drain();

        // 5: long burst with a mid-burst stall
        for (int k = 0; k < 8; k++) issue(1'b1, 32'h00200 + 4 * k, 2, 0, $urandom);
        wait_drain();
        issue(1'b0, 32'h00200, 2, 7, 32'h0);
        @(negedge clk_in);
        rr_low = 5;
        for (int k = 0; k < 5; k++) begin
            check("burst_req_ready_low", 32'(req_ready), 32'd0);
            @(negedge clk_in);
        end
        @(posedge clk_in);
        #1;
        issue(1'b0, 32'h00100, 2, 0, 32'h0);
        wait_drain();

        // 6: reset in the middle of a burst
        for (int k = 0; k < 4; k++) issue(1'b1, 32'h00400 + 4 * k, 2, 0, $urandom);
        wait_drain();
        issue(1'b0, 32'h00400, 2, 15, 32'h0);
        step(3);
        rst_in = 1'b1;
        @(negedge clk_in);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk_in);
        #1;
        sb_q.delete();
        @(negedge clk_in);
        check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_resp_rdata", resp_rdata, 32'd0);
        check("mid_rst_resp_last", 32'(resp_last), 32'd0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        check("after_release_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk_in);
        #1;
        issue(1'b0, 32'h00100, 2, 0, 32'h0);
        issue(1'b0, 32'h00400, 2, 3, 32'h0);
        wait_drain();

        // Randomised traffic with random backpressure
        rr_rand = 1'b1;
        for (int n = 0; n < 300; n++) begin
            bit we;
            int addr;
            int len;
            we   = ($urandom_range(0, 1) == 1);
            addr = ($urandom_range(0, 7) == 0) ? ((CAP - 8 + $urandom_range(0, 15)) % CAP)
                                               : (32'h00300 + $urandom_range(0, 127));
            len  = we ? 0 : $urandom_range(0, 15);
            issue(we, addr, $urandom_range(0, 3), len, $urandom);
            if ($urandom_range(0, 3) == 0) step($urandom_range(1, 2));
        end
        rr_rand = 1'b0;
        wait_drain();
        step(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
